adc_frame_align: RTL

- Upstream of the AXI-lite register block; produces its status inputs `bitslip_count`, `clk_align_frame_valid` (as `frame_valid`) and consumes `mmcm_locked` and the `reset` control bit (as `restart`).
- Watches the deserialized ADC frame-clock word, pulses the deserializer bitslip until the word matches the expected pattern, then declares and supervises frame lock.
- Sits in the ADC clock domain, beside the deserializers.

---
 rtl/adc_frame_align_pkg.sv | 21 ++
 rtl/adc_frame_align_run_counter.sv | 30 +++
 rtl/adc_frame_align.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adc_frame_align_pkg.sv
// Shared types and helpers for the ADC frame-clock alignment block.
package adc_frame_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4
  } align_state_e;

  localparam logic [7:0] DEFAULT_FRAME_PATTERN = 8'hF0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/adc_frame_align_run_counter.sv
// Saturating consecutive-event counter; hit flags the event that reaches LIMIT.
module align_run_counter
  import adc_frame_align_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam int unsigned CW = clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CW'(LIMIT))) begin
      count <= count + CW'(1);
    end
  end

  assign hit = inc && (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/adc_frame_align.sv
// Frame-clock alignment: bitslips the deserializers until the frame word
// matches FRAME_PATTERN, then supervises lock and re-hunts on sustained loss.
module adc_frame_align
  import adc_frame_align_pkg::*;
#(
  parameter int unsigned             FRAME_WIDTH   = 8,
  parameter logic [FRAME_WIDTH-1:0]  FRAME_PATTERN = FRAME_WIDTH'(DEFAULT_FRAME_PATTERN),
  parameter int unsigned             SETTLE_CYCLES = 16,
  parameter int unsigned             MATCH_COUNT   = 64,
  parameter int unsigned             LOSS_COUNT    = 4
) (
  input  logic                   adc_clock,
  input  logic                   rst_n,
  input  logic                   mmcm_locked,
  input  logic                   restart,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  output logic                   bitslip,
  output logic [3:0]             bitslip_count,
  output logic                   frame_valid,
  output logic                   align_fail
);

  localparam int unsigned SW = clog2(SETTLE_CYCLES + 1);
  localparam int unsigned AW = clog2(FRAME_WIDTH + 1);

  align_state_e  state, next_state;
  logic [SW-1:0] settle_cnt;
  logic [AW-1:0] attempt_cnt;
  logic          override, is_match, settle_done;
  logic          match_inc, match_clear, match_hit;
  logic          loss_inc, loss_clear, loss_hit;

  assign override    = !mmcm_locked || restart;
  assign is_match    = (frame_data == FRAME_PATTERN);
  assign settle_done = (settle_cnt >= SW'(SETTLE_CYCLES - 1));

  assign match_inc   = (state == ST_CHECK) && is_match;
  assign match_clear = override || (state != ST_CHECK) || !is_match;
  assign loss_inc    = (state == ST_LOCKED) && !is_match;
  assign loss_clear  = override || (state != ST_LOCKED) || is_match;

  align_run_counter #(.LIMIT(MATCH_COUNT)) u_match_run (
    .clk   (adc_clock),
    .rst_n (rst_n),
    .clear (match_clear),
    .inc   (match_inc),
    .hit   (match_hit)
  );

  align_run_counter #(.LIMIT(LOSS_COUNT)) u_loss_run (
    .clk   (adc_clock),
    .rst_n (rst_n),
    .clear (loss_clear),
    .inc   (loss_inc),
    .hit   (loss_hit)
  );

  always_ff @(posedge adc_clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (override) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   next_state = ST_SETTLE;
        ST_SETTLE: if (settle_done) next_state = ST_CHECK;
        ST_CHECK: begin
          if (!is_match)      next_state = ST_SLIP;
          else if (match_hit) next_state = ST_LOCKED;
        end
        ST_SLIP:   next_state = ST_SETTLE;
        ST_LOCKED: if (loss_hit) next_state = ST_SETTLE;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Settle window starts at zero on every entry since SETTLE never follows itself.
  always_ff @(posedge adc_clock or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state != ST_SETTLE) begin
      settle_cnt <= '0;
    end else if (!settle_done) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // Outputs are decoded from next_state so they line up with the state they describe.
  always_ff @(posedge adc_clock or negedge rst_n) begin
    if (!rst_n) begin
      bitslip       <= 1'b0;
      frame_valid   <= 1'b0;
      bitslip_count <= '0;
      align_fail    <= 1'b0;
      attempt_cnt   <= '0;
    end else begin
      bitslip     <= (next_state == ST_SLIP);
      frame_valid <= (next_state == ST_LOCKED);
      if (next_state == ST_IDLE) begin
        bitslip_count <= '0;
        align_fail    <= 1'b0;
        attempt_cnt   <= '0;
      end else if (next_state == ST_SLIP) begin
        bitslip_count <= bitslip_count + 4'd1;
        if (attempt_cnt >= AW'(FRAME_WIDTH - 1)) begin
          attempt_cnt <= '0;
          align_fail  <= 1'b1;
        end else begin
          attempt_cnt <= attempt_cnt + AW'(1);
        end
      end
    end
  end

endmodule
